// File: rtl/zeroriscy_ex_dispatch_if.sv
// Handshake bundle between the EX dispatcher, the ID stage and the multi-cycle units.
// The dispatcher takes the slave view; whatever drives ops and unit responses takes the master view.
interface zeroriscy_ex_dispatch_if #(
  parameter int NUM_UNITS  = 3,
  parameter int DATA_WIDTH = 32
);
  logic                            op_valid_i;
  logic [NUM_UNITS-1:0]            unit_sel_i;
  logic [DATA_WIDTH-1:0]           alu_result_i;
  logic                            flush_i;
  logic [NUM_UNITS-1:0]            unit_start_o;
  logic [NUM_UNITS-1:0]            unit_done_i;
  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i;
  logic [DATA_WIDTH-1:0]           result_o;
  logic                            ex_ready_o;
  logic                            busy_o;
  logic                            timeout_o;
  logic                            multi_sel_err_o;

  modport slave (
    input  op_valid_i, unit_sel_i, alu_result_i, flush_i, unit_done_i, unit_result_i,
    output unit_start_o, result_o, ex_ready_o, busy_o, timeout_o, multi_sel_err_o
  );

  modport master (
    output op_valid_i, unit_sel_i, alu_result_i, flush_i, unit_done_i, unit_result_i,
    input  unit_start_o, result_o, ex_ready_o, busy_o, timeout_o, multi_sel_err_o
  );
endinterface

// File: rtl/zeroriscy_ex_dispatch.sv
// EX-stage dispatcher: issues one op at a time to NUM_UNITS multi-cycle units, with watchdog and flush.
// Optional macro ZERORISCY_EX_DISPATCH_BYPASS_EN forwards a unit result in its done cycle, skipping DONE.
module zeroriscy_ex_dispatch #(
  parameter int NUM_UNITS      = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  zeroriscy_ex_dispatch_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_UNITS-1:0]  sel_q, sel_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [NUM_UNITS-1:0]  start_q, start_d;
  logic                  timeout_q, timeout_d;
  logic                  merr_q, merr_d;

  logic                  req_s;
  logic [NUM_UNITS-1:0]  low_sel_s;
  logic                  multi_s;
  logic                  done_hit_s;
  logic                  count_end_s;
  logic [DATA_WIDTH-1:0] unit_res_s;

  logic [NUM_UNITS-1:0]  unit_start_s;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  ex_ready_s;
  logic                  busy_s;
  logic                  timeout_s;
  logic                  merr_s;

  // Lowest set bit wins so a malformed multi-hot request still maps to exactly one unit.
  assign req_s       = bus.op_valid_i && (bus.unit_sel_i != '0);
  assign low_sel_s   = bus.unit_sel_i & (~bus.unit_sel_i + NUM_UNITS'(1));
  assign multi_s     = (bus.unit_sel_i & (bus.unit_sel_i - NUM_UNITS'(1))) != '0;
  assign done_hit_s  = (bus.unit_done_i & sel_q) != '0;
  assign count_end_s = (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    unit_res_s = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (sel_q[k]) begin
        unit_res_s = unit_res_s | bus.unit_result_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        unit_res_s = unit_res_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    count_d   = count_q;
    result_d  = result_q;
    start_d   = '0;
    timeout_d = 1'b0;
    merr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush_i && req_s) begin
          sel_d   = low_sel_s;
          merr_d  = multi_s;
          count_d = '0;
          start_d = low_sel_s;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Flush outranks both a done strobe and the watchdog; result_q is left alone.
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (done_hit_s) begin
          result_d = unit_res_s;
`ifdef ZERORISCY_EX_DISPATCH_BYPASS_EN
          state_d  = IDLE;
`else
          state_d  = DONE;
`endif
        end else if (count_end_s) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      start_q   <= '0;
      timeout_q <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      result_q  <= result_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      merr_q    <= merr_d;
    end
  end

  // Everything is forced low while in reset, even before the first reset edge has settled the state.
  always_comb begin
    unit_start_s = '0;
    result_s     = '0;
    ex_ready_s   = 1'b0;
    busy_s       = 1'b0;
    timeout_s    = 1'b0;
    merr_s       = 1'b0;
    if (!rst) begin
      busy_s       = (state_q != IDLE);
      merr_s       = merr_q;
      unit_start_s = bus.flush_i ? '0 : start_q;
      case (state_q)
        IDLE: begin
          ex_ready_s = !req_s;
          result_s   = bus.alu_result_i;
        end
        WAIT: begin
`ifdef ZERORISCY_EX_DISPATCH_BYPASS_EN
          if (done_hit_s && !bus.flush_i) begin
            ex_ready_s = 1'b1;
            result_s   = unit_res_s;
          end else begin
            ex_ready_s = 1'b0;
            result_s   = result_q;
          end
`else
          result_s = result_q;
`endif
        end
        DONE: begin
          ex_ready_s = !bus.flush_i;
          timeout_s  = timeout_q && !bus.flush_i;
          result_s   = result_q;
        end
        default: begin
          result_s = '0;
        end
      endcase
    end else begin
      busy_s = 1'b0;
    end
  end

  assign bus.unit_start_o    = unit_start_s;
  assign bus.result_o        = result_s;
  assign bus.ex_ready_o      = ex_ready_s;
  assign bus.busy_o          = busy_s;
  assign bus.timeout_o       = timeout_s;
  assign bus.multi_sel_err_o = merr_s;

endmodule

// File: doc/zeroriscy_ex_dispatch.md
Name: zeroriscy_ex_dispatch

Overview:
Parametrised N-channel execute-stage dispatcher; generalises the EX result/ready muxing to NUM_UNITS multi-cycle functional units (mul/div, BNN, future accelerators). Takes a one-hot unit select from ID and issues a one-cycle start pulse to that unit. Waits for the unit's done with a watchdog, registers the result and drives ex_ready_o and the regfile write data. Single-cycle ALU ops bypass the FSM.

Parameters:
NUM_UNITS, 3, number of multi-cycle unit channels (1..8)
DATA_WIDTH, 32, result/operand width
TIMEOUT_CYCLES, 255, max WAIT cycles before abort (>=2); counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
op_valid_i  in  1  EX holds a valid instruction
unit_sel_i  in  NUM_UNITS  one-hot unit request; all-zero = single-cycle ALU op
alu_result_i  in  DATA_WIDTH  ALU result for single-cycle ops
flush_i  in  1  kill in-flight op (exception/debug)
unit_start_o  out  NUM_UNITS  one-cycle start pulse to the selected unit
unit_done_i  in  NUM_UNITS  per-unit completion strobe
unit_result_i  in  NUM_UNITS*DATA_WIDTH  packed unit results; unit k at [k*DATA_WIDTH +: DATA_WIDTH]
result_o  out  DATA_WIDTH  regfile write data
ex_ready_o  out  1  EX finished; ID may advance
busy_o  out  1  FSM not IDLE
timeout_o  out  1  one-cycle pulse: op aborted by watchdog
multi_sel_err_o  out  1  one-cycle pulse: multi-hot unit_sel_i accepted

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- While rst=1: state=IDLE, sel_q=0, count=0, result_q=0. Outputs unit_start_o=0, ex_ready_o=0, busy_o=0, timeout_o=0, multi_sel_err_o=0, result_o=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no unit selected (op_valid_i=0 or unit_sel_i=0): ex_ready_o=1; result_o=alu_result_i, combinational.
- IDLE, accept (op_valid_i=1, unit_sel_i!=0, flush_i=0):
  - Latch sel_q = lowest set bit of unit_sel_i.
  - multi_sel_err_o=1 next cycle if more than one bit was set.
  - count=0; ex_ready_o=0 this cycle; next state WAIT.
- WAIT:
  - unit_start_o = sel_q during the first WAIT cycle only (registered pulse).
  - unit_done_i & sel_q accepted any WAIT cycle, including the start cycle.
  - On done: result_q = selected unit_result_i slice; next state DONE.
  - Done strobes from non-selected units are ignored.
  - Each WAIT cycle without done increments count.
  - When count==TIMEOUT_CYCLES-1 with no done: result_q=0, timeout_o=1 during the following DONE cycle; next state DONE.
  - ex_ready_o=0.
- DONE: ex_ready_o=1, result_o=result_q for exactly one cycle; next state IDLE. A new op can be accepted in the following IDLE cycle.
- Minimum latency: accept cycle T, start pulse at T+1, done at T+1, ex_ready_o at T+2 (3 cycles total).
- flush_i=1 in any state: next state IDLE, no ex_ready_o pulse, no start pulse issued, timeout_o suppressed, result_q unchanged. Flush takes priority over a simultaneous done or timeout. Flush while IDLE blocks acceptance that cycle.
- busy_o = (state != IDLE).

Optional Feature:
ZERORISCY_EX_DISPATCH_BYPASS_EN
- Defined: in WAIT, a selected done forwards the unit result combinationally. result_o = unit slice and ex_ready_o=1 in the same cycle; next state IDLE, DONE skipped.
  - Minimum latency drops to 2 cycles.
  - The timeout path still goes through DONE.
- Undefined: registered DONE path exactly as in Behaviour.

Test Plan:
- ALU op: op_valid_i=1, unit_sel_i=0, alu_result_i=0x0000_1234 -> ex_ready_o=1 and result_o=0x1234 same cycle; unit_start_o stays 0.
- Unit 1 op: unit_sel_i=3'b010 at T; unit 1 asserts done at T+3 with result 0xDEAD_BEEF -> unit_start_o=3'b010 only at T+1; ex_ready_o=1 and result_o=0xDEADBEEF only at T+4; busy_o high T+1..T+4.
- Wrong-unit done: sel=3'b100; unit 0 done at T+2 with 0x1111, unit 2 done at T+5 with 0x2222 -> result_o=0x2222 at T+6; the 0x1111 strobe is ignored.
- Timeout: TIMEOUT_CYCLES=4, sel=3'b001, no done -> DONE entered after 4 WAIT cycles; ex_ready_o=1, result_o=0, timeout_o=1 for one cycle; next op accepted normally.
- Multi-hot plus flush: unit_sel_i=3'b110 -> start on unit 1 only, multi_sel_err_o pulses once. Then flush_i in the same cycle as unit 1 done -> no ex_ready_o pulse, back in IDLE next cycle.
- Reset mid-op: rst=1 during WAIT -> next cycle all outputs 0, state IDLE; after rst deasserts, ALU op completes in 1 cycle. With bypass macro defined, repeat the unit 1 test -> ex_ready_o at T+3.
